ks_sub_pipe_16bit: RTL and testbench

Two-stage pipelined 16-bit Kogge-Stone subtractor with borrow-in/borrow-out, status flags and a valid/ready handshake on both sides. It computes D = A − B − Bin as A + ~B + ~Bin through a radix-2 parallel-prefix carry tree. The tree is split across two register stages so it can run at the system clock. It complements the combinational Kogge-Stone adder and gives the datapath a back-pressurable subtract path.

---
 rtl/ks_sub_pipe_16bit.sv | 127 ++++++++++++
 tb/tb_ks_sub_pipe_16bit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ks_sub_pipe_16bit.sv
// Two-stage pipelined Kogge-Stone subtractor D = A - B - Bin (A + ~B + ~Bin) with borrow/zero/neg/ovf flags.
// Latency 2 cycles, 1 beat/cycle; on out_ready low both stages hold and in_ready drops only once both are full.
module ks_sub_pipe_16bit #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int LVLS = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
  } gp_t;

  typedef struct packed {
    gp_t              grp;
    logic [WIDTH-1:0] p_raw;
    logic             c0;
    logic             a_msb;
    logic             b_msb;
  } s1_t;

  // Prefix levels [first, last); walking bits downward lets the update run in place.
  function automatic gp_t ks_levels(input gp_t x, input int first, input int last);
    gp_t y;
    int  d;
    y = x;
    for (int l = first; l < last; l++) begin
      d = 1 << l;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i >= d) begin
          y.g[i] = y.g[i] | (y.p[i] & y.g[i-d]);
          y.p[i] = y.p[i] & y.p[i-d];
        end
      end
    end
    return y;
  endfunction

  function automatic logic [WIDTH-1:0] ks_final_g(input gp_t x);
    gp_t y;
    y = ks_levels(x, SPLIT, LVLS);
    return y.g;
  endfunction

  logic             s1_valid;
  logic             s2_valid;
  logic             adv1;
  logic             adv2;
  s1_t              s1;
  s1_t              s1_d;
  gp_t              gp0;
  logic [WIDTH-1:0] g2;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;

  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // Carry-in (~Bin) is absorbed into bit 0's generate so the tree yields true carries.
  always_comb begin
    gp0       = '0;
    gp0.g     = A & ~B;
    gp0.p     = A ^ ~B;
    gp0.g[0]  = gp0.g[0] | (gp0.p[0] & ~Bin);
    s1_d       = '0;
    s1_d.grp   = ks_levels(gp0, 0, SPLIT);
    s1_d.p_raw = gp0.p;
    s1_d.c0    = ~Bin;
    s1_d.a_msb = A[WIDTH-1];
    s1_d.b_msb = B[WIDTH-1];
  end

  always_comb begin
    g2    = ks_final_g(s1.grp);
    carry = {g2[WIDTH-2:0], s1.c0};
    sum   = s1.p_raw ^ carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) s1 <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      D        <= '0;
      Bout     <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        D    <= sum;
        Bout <= ~g2[WIDTH-1];
        zero <= (sum == '0);
        neg  <= sum[WIDTH-1];
        ovf  <= (s1.a_msb ^ s1.b_msb) & (sum[WIDTH-1] ^ s1.a_msb);
      end
    end
  end

endmodule

// File: tb/tb_ks_sub_pipe_16bit.sv
// Bench for ks_sub_pipe_16bit: directed vector table, stall/reset sequences, random stream vs arithmetic model.
module tb_ks_sub_pipe_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        bout;
  logic        zero;
  logic        neg;
  logic        ovf;

  always #5 clk = ~clk;

  ks_sub_pipe_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d),
    .Bout      (bout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    res_t        exp;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  res_t q[$];
  vec_t vecs[10];

  function automatic res_t model(input logic [15:0] a_i, input logic [15:0] b_i, input logic bin_i);
    res_t r;
    int   diff;
    int   sdiff;
    diff   = int'(a_i) - int'(b_i) - int'(bin_i);
    sdiff  = int'($signed(a_i)) - int'($signed(b_i)) - int'(bin_i);
    r.d    = diff[15:0];
    r.bout = (diff < 0);
    r.zero = (r.d == 16'h0000);
    r.neg  = r.d[15];
    r.ovf  = (sdiff > 32767) || (sdiff < -32768);
    return r;
  endfunction

  function automatic vec_t mkv(input logic [15:0] a_i, input logic [15:0] b_i, input logic bin_i,
                               input logic [15:0] d_i, input logic bo, input logic z, input logic n,
                               input logic o);
    vec_t v;
    v.a   = a_i;
    v.b   = b_i;
    v.bin = bin_i;
    v.exp = {d_i, bo, z, n, o};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_res(input string name, input res_t exp);
    res_t act;
    act = {d, bout, zero, neg, ovf};
    check(name, 32'(act), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: back-to-back beats with out_ready low in cycles 4..6; mode 1: random valid/ready.
  task automatic run_stream(input int nbeats, input int mode, input int max_cycles);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int low_cnt = 0;
    while (got < nbeats && cyc < max_cycles) begin
      if (mode == 0) out_ready = !(cyc >= 4 && cyc <= 6);
      else           out_ready = ($urandom_range(0, 99) < 70);
      a        = 16'($urandom);
      b        = 16'($urandom);
      bin      = 1'($urandom);
      in_valid = (sent < nbeats) && (mode == 0 || $urandom_range(0, 99) < 80);
      #1;
      check("in_ready_rule", in_ready, (out_ready || q.size() < 2));
      if (mode == 0 && !out_ready && !in_ready) low_cnt++;
      if (mode == 0 && cyc > 6 && q.size() > 0) check("stream_no_gap", out_valid, 1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          check_res("stream_res", q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin));
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", got, nbeats);
    check("stream_left", q.size(), 0);
    if (mode == 0) check("stall_in_ready_low_cycles", low_cnt, 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mkv(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[1] = mkv(16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[2] = mkv(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[3] = mkv(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[4] = mkv(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
    vecs[5] = mkv(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[6] = mkv(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[7] = mkv(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[8] = mkv(16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[9] = mkv(16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    bin       = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check_res("reset_outputs", '0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);

    // Directed table: one beat at a time, exact two-edge latency.
    foreach (vecs[k]) begin
      in_valid  = 1'b1;
      a         = vecs[k].a;
      b         = vecs[k].b;
      bin       = vecs[k].bin;
      out_ready = 1'b1;
      #1;
      check("tbl_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      check("tbl_latency_early", out_valid, 0);
      step();
      check("tbl_latency_valid", out_valid, 1);
      check_res("tbl_result", vecs[k].exp);
      step();
    end

    run_stream(8, 0, 100);

    // Reset with two beats in flight, then a first post-reset beat.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'h00F0; b = 16'h0001; bin = 1'b0;
    step();
    a = 16'h1111; b = 16'h0002; bin = 1'b0;
    step();
    in_valid = 1'b0;
    check("rst_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check_res("rst_async_outputs", '0);
    q.delete();
    step();
    check("rst_hold_valid", out_valid, 0);
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a = 16'hFFFF; b = 16'hFFFF; bin = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("post_rst_early", out_valid, 0);
    step();
    check("post_rst_valid", out_valid, 1);
    check_res("post_rst_result", {16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0});
    step();

    run_stream(10000, 1, 40000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
